// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_pkg
//  Purpose  : Shared key-event definitions: event kinds, event field layout,
//             auto-repeat state encoding and an event-packing helper.
//             Also imported by the IO bus decoder.
//  Revision : 1.0  initial release
// ============================================================================
package key_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_REPEAT  = 2'b10;
  localparam logic [1:0] KIND_RSVD    = 2'b11;

  // Event byte layout: {kind[1:0], 1'b0, idx[4:0]}
  localparam int EV_W        = 8;
  localparam int EV_KIND_LSB = 6;
  localparam int EV_IDX_W    = 5;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rpt_state_t;

  function automatic logic [EV_W-1:0] make_event(input logic [1:0] kind,
                                                 input logic [EV_IDX_W-1:0] idx);
    return {kind, 1'b0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : key_evt_fifo
//  Purpose  : First-word-fall-through FIFO with occupancy count. Head data is
//             driven combinationally from storage; reads zero when empty.
//             A push into a full FIFO is accepted when a pop happens in the
//             same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module key_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; pointer width makes wrap modulo DEPTH implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_queue
//  Purpose  : Turns debounced active-low key levels into coded press/release
//             (and optional repeat) events, holds one pending event per key,
//             and queues them through a FWFT FIFO popped by the CPU.
//  Options  : KEY_REPEAT_EN - build the auto-repeat FSM and counter.
//  Revision : 1.0  initial release
// ============================================================================
module key_event_queue
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 5,
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 10_000_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           key_db,
  input  logic                          rd_en,
  output logic                          ev_valid,
  output logic [7:0]                    ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [NUM_KEYS-1:0]           key_held
);

  logic [NUM_KEYS-1:0] key_r;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_rel;
  logic [NUM_KEYS-1:0] key_edge;
  logic [NUM_KEYS-1:0] slot_vld;
  logic [1:0]          slot_kind [NUM_KEYS];
  logic [NUM_KEYS-1:0] sel_vec;
  logic [NUM_KEYS-1:0] grant;
  logic [NUM_KEYS-1:0] rpt_load;
  logic                sel_found;
  logic                can_push;
  logic                push;
  logic [7:0]          push_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                ovf_set;

  // Level pipeline; reset to "released" so a key held through reset yields a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= '1;
      key_q <= '1;
    end else begin
      key_r <= key_db;
      key_q <= key_r;
    end
  end

  assign key_held  = ~key_r;
  assign key_press = key_q & ~key_r;
  assign key_rel   = ~key_q & key_r;
  assign key_edge  = key_press | key_rel;

  // When full, a pop in the same cycle frees the entry being pushed.
  assign can_push = !fifo_full || rd_en;

  // Lowest-index valid slot wins the single FIFO write port.
  always_comb begin
    sel_vec   = '0;
    sel_found = 1'b0;
    push_data = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (slot_vld[i] && !sel_found) begin
        sel_found  = 1'b1;
        sel_vec[i] = 1'b1;
        push_data  = make_event(slot_kind[i], EV_IDX_W'(i));
      end
    end
    push  = sel_found && can_push;
    grant = can_push ? sel_vec : '0;
  end

  // Pending slots: edges load (overwriting an unsent event), repeats fill only free slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < NUM_KEYS; i++) slot_kind[i] <= KIND_PRESS;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_edge[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_kind[i] <= key_press[i] ? KIND_PRESS : KIND_RELEASE;
        end else if (rpt_load[i] && (!slot_vld[i] || grant[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_kind[i] <= KIND_REPEAT;
        end else if (grant[i]) begin
          slot_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // An event is lost only when an edge hits a slot that is not draining this cycle.
  assign ovf_set = |(key_edge & slot_vld & ~grant);

  // Sticky overflow flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef KEY_REPEAT_EN
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX) + 1;
  localparam int TGT_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  rpt_state_t       r_state, r_state_nx;
  logic [RC_W-1:0]  r_cnt, r_cnt_nx;
  logic [TGT_W-1:0] r_tgt, r_tgt_nx;
  logic             tgt_rel;
  logic             rpt_fire;

  // Repeat FSM state, shared counter and target key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= r_state_nx;
      r_cnt   <= r_cnt_nx;
      r_tgt   <= r_tgt_nx;
    end
  end

  // Next state: any press (lowest index) retargets; target release stops repeating.
  always_comb begin
    r_state_nx = r_state;
    r_cnt_nx   = r_cnt;
    r_tgt_nx   = r_tgt;
    rpt_fire   = 1'b0;
    rpt_load   = '0;
    tgt_rel    = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (TGT_W'(i) == r_tgt) tgt_rel = key_rel[i];
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) r_tgt_nx = TGT_W'(i);
    end
    if (|key_press) begin
      r_state_nx = R_DELAY;
      r_cnt_nx   = '0;
    end else begin
      case (r_state)
        R_DELAY: begin
          if (tgt_rel) begin
            r_state_nx = R_IDLE;
            r_cnt_nx   = '0;
          end else if (r_cnt == RC_W'(REPEAT_DELAY - 1)) begin
            rpt_fire   = 1'b1;
            r_state_nx = R_REPEAT;
            r_cnt_nx   = '0;
          end else begin
            r_cnt_nx   = r_cnt + 1'b1;
          end
        end
        R_REPEAT: begin
          if (tgt_rel) begin
            r_state_nx = R_IDLE;
            r_cnt_nx   = '0;
          end else if (r_cnt == RC_W'(REPEAT_PERIOD - 1)) begin
            rpt_fire   = 1'b1;
            r_cnt_nx   = '0;
          end else begin
            r_cnt_nx   = r_cnt + 1'b1;
          end
        end
        R_IDLE:  r_cnt_nx = '0;
        default: begin
          r_state_nx = R_IDLE;
          r_cnt_nx   = '0;
        end
      endcase
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rpt_fire && (TGT_W'(i) == r_tgt)) rpt_load[i] = 1'b1;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rpt_load   = '0;
`endif

  key_evt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (ev_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (ev_count)
  );

  assign ev_valid = !fifo_empty;

endmodule
`default_nettype wire
